// File: rtl/mac_accumulator.sv
// Accumulates a stream of unsigned products into dot-product sums and hands each
// finished sum to downstream through a one-entry valid/ready output register.
module mac_accumulator #(
    parameter int WIDTH     = 16,
    parameter int ACC_WIDTH = 40,
    parameter int SATURATE  = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [2*WIDTH-1:0]     prod_in,
    input  logic                   prod_valid,
    input  logic                   prod_last,
    output logic                   prod_ready,
    output logic [ACC_WIDTH-1:0]   acc_out,
    output logic                   acc_ovf,
    output logic [15:0]            acc_count,
    output logic                   acc_valid,
    input  logic                   acc_ready
);

    localparam int PW = 2 * WIDTH;

    logic [ACC_WIDTH-1:0] sum_r;
    logic [15:0]          cnt_r;
    logic                 ovf_r;
    logic                 first_r;

    logic                 accept_s;
    logic [ACC_WIDTH:0]   base_s;
    logic [ACC_WIDTH:0]   s_s;
    logic                 ovf_term_s;
    logic [ACC_WIDTH-1:0] sum_next_s;
    logic [15:0]          cnt_next_s;
    logic                 ovf_next_s;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        if (v == 16'hFFFF) begin
            return 16'hFFFF;
        end else begin
            return v + 16'd1;
        end
    endfunction

    // Term acceptance: the output register must be free or draining this cycle.
    always_comb begin
        prod_ready = 1'b0;
        if (rst) begin
            prod_ready = 1'b0;
        end else begin
            prod_ready = !acc_valid || acc_ready;
        end
        accept_s = prod_valid && prod_ready;
    end

    // Next running sum, count and sticky overflow for the term on prod_in.
    always_comb begin
        base_s     = '0;
        sum_next_s = '0;
        if (first_r) begin
            base_s = '0;
        end else begin
            base_s = {1'b0, sum_r};
        end
        s_s        = base_s + {{(ACC_WIDTH + 1 - PW){1'b0}}, prod_in};
        ovf_term_s = s_s[ACC_WIDTH];
        // A saturated sum stays at max: any further add overflows again and re-clamps.
        if (ovf_term_s && (SATURATE != 0)) begin
            sum_next_s = {ACC_WIDTH{1'b1}};
        end else begin
            sum_next_s = s_s[ACC_WIDTH-1:0];
        end
        if (first_r) begin
            cnt_next_s = 16'd1;
            ovf_next_s = ovf_term_s;
        end else begin
            cnt_next_s = sat_inc16(cnt_r);
            ovf_next_s = ovf_r | ovf_term_s;
        end
    end

    // Running state: FIRST until a non-last term arrives, back to FIRST on the last term.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_r   <= '0;
            cnt_r   <= 16'd0;
            ovf_r   <= 1'b0;
            first_r <= 1'b1;
        end else if (accept_s) begin
            if (prod_last) begin
                first_r <= 1'b1;
            end else begin
                sum_r   <= sum_next_s;
                cnt_r   <= cnt_next_s;
                ovf_r   <= ovf_next_s;
                first_r <= 1'b0;
            end
        end else begin
            first_r <= first_r;
        end
    end

    // Output buffer: a last-term accept reloads it even while the old result drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_out   <= '0;
            acc_ovf   <= 1'b0;
            acc_count <= 16'd0;
            acc_valid <= 1'b0;
        end else if (accept_s && prod_last) begin
            acc_out   <= sum_next_s;
            acc_ovf   <= ovf_next_s;
            acc_count <= cnt_next_s;
            acc_valid <= 1'b1;
        end else if (acc_valid && acc_ready) begin
            acc_valid <= 1'b0;
        end else begin
            acc_valid <= acc_valid;
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Self-checking bench for mac_accumulator: vector table plus corner-case sequences,
// results checked against an expectation queue as the DUT hands them off.
module tb_mac_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] prod_in;
    logic        prod_valid;
    logic        prod_last;
    logic        acc_ready;

    logic        prod_ready;
    logic [39:0] acc_out;
    logic        acc_ovf;
    logic [15:0] acc_count;
    logic        acc_valid;

    logic        pr_s, pr_w;
    logic [32:0] out_s, out_w;
    logic        ovf_s, ovf_w;
    logic [15:0] cnt_s, cnt_w;
    logic        val_s, val_w;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [39:0] s;
        logic [15:0] c;
        logic        o;
    } res_t;

    typedef struct packed {
        logic [2:0]       n;
        logic [3:0][31:0] t;
        logic [39:0]      s;
        logic [15:0]      c;
        logic             o;
    } vec_t;

    res_t expq[$];
    vec_t tbl[4];

    always #5 clk = ~clk;

    mac_accumulator #(.WIDTH(16), .ACC_WIDTH(40), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_last(prod_last), .prod_ready(prod_ready), .acc_out(acc_out),
        .acc_ovf(acc_ovf), .acc_count(acc_count), .acc_valid(acc_valid),
        .acc_ready(acc_ready)
    );

    mac_accumulator #(.WIDTH(16), .ACC_WIDTH(33), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_last(prod_last), .prod_ready(pr_s), .acc_out(out_s),
        .acc_ovf(ovf_s), .acc_count(cnt_s), .acc_valid(val_s),
        .acc_ready(acc_ready)
    );

    mac_accumulator #(.WIDTH(16), .ACC_WIDTH(33), .SATURATE(0)) dut_w (
        .clk(clk), .rst(rst), .prod_in(prod_in), .prod_valid(prod_valid),
        .prod_last(prod_last), .prod_ready(pr_w), .acc_out(out_w),
        .acc_ovf(ovf_w), .acc_count(cnt_w), .acc_valid(val_w),
        .acc_ready(acc_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Offer one term and hold it until accepted (bounded wait).
    task automatic send(input logic [31:0] d, input logic last);
        int waitc;
        waitc      = 0;
        prod_in    = d;
        prod_last  = last;
        prod_valid = 1'b1;
        @(negedge clk);
        while (!prod_ready && waitc < 50) begin
            @(negedge clk);
            waitc++;
        end
        if (!prod_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got prod_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
    endtask

    task automatic push(input logic [39:0] s, input logic [15:0] c, input logic o);
        res_t r;
        r.s = s;
        r.c = c;
        r.o = o;
        expq.push_back(r);
    endtask

    task automatic run_vec(input vec_t v);
        push(v.s, v.c, v.o);
        for (int k = 0; k < int'(v.n); k++) begin
            send(v.t[k], (k == int'(v.n) - 1));
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard: every result taken by downstream must match the oldest expectation.
    always @(negedge clk) begin
        if (acc_valid === 1'b1 && acc_ready === 1'b1) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got acc_out=%0h with no expected result", acc_out);
            end else begin
                chk("sb_acc_out", 64'(acc_out), 64'(expq[0].s));
                chk("sb_acc_count", 64'(acc_count), 64'(expq[0].c));
                chk("sb_acc_ovf", 64'(acc_ovf), 64'(expq[0].o));
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        tbl[0] = '{n: 3'd3, t: {32'd0, 32'd3, 32'd2, 32'd1}, s: 40'd6, c: 16'd3, o: 1'b0};
        tbl[1] = '{n: 3'd4, t: {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
                   s: 40'h03FFFFFFFC, c: 16'd4, o: 1'b0};
        tbl[2] = '{n: 3'd1, t: {32'd0, 32'd0, 32'd0, 32'd0}, s: 40'd0, c: 16'd1, o: 1'b0};
        tbl[3] = '{n: 3'd2, t: {32'd0, 32'd0, 32'h11111111, 32'h12345678},
                   s: 40'h0023456789, c: 16'd2, o: 1'b0};

        rst        = 1'b1;
        prod_in    = 32'd0;
        prod_valid = 1'b1;
        prod_last  = 1'b0;
        acc_ready  = 1'b1;
        idle(2);
        chk("rst_outputs", {acc_out, acc_count, acc_ovf, acc_valid}, 64'd0);
        chk("rst_prod_ready", 64'(prod_ready), 64'd0);
        prod_valid = 1'b0;
        rst        = 1'b0;
        idle(1);
        chk("post_rst_ready", 64'(prod_ready), 64'd1);

        // Basic dot product with exact one-cycle latency.
        push(40'd600, 16'd3, 1'b0);
        send(32'd100, 1'b0);
        send(32'd200, 1'b0);
        send(32'd300, 1'b1);
        chk("basic_latency_valid", 64'(acc_valid), 64'd1);
        idle(1);
        chk("basic_valid_drops", 64'(acc_valid), 64'd0);

        // Single-term vector immediately followed by a two-term vector.
        push(40'hFFFFFFFF, 16'd1, 1'b0);
        send(32'hFFFFFFFF, 1'b1);
        push(40'd12, 16'd2, 1'b0);
        send(32'd5, 1'b0);
        send(32'd7, 1'b1);
        chk("b2b_out", 64'(acc_out), 64'd12);
        chk("b2b_count", 64'(acc_count), 64'd2);

        for (int i = 0; i < 4; i++) begin
            run_vec(tbl[i]);
        end

        // Saturation and wrap on the 33-bit instances.
        push(40'h02FFFFFFFD, 16'd3, 1'b0);
        send(32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 1'b1);
        chk("sat_valid", {62'd0, val_s, val_w}, 64'd3);
        chk("sat_out", 64'(out_s), 64'h1FFFFFFFF);
        chk("sat_ovf", 64'(ovf_s), 64'd1);
        chk("sat_count", 64'(cnt_s), 64'd3);
        chk("wrap_out", 64'(out_w), 64'h0FFFFFFFD);
        chk("wrap_ovf", 64'(ovf_w), 64'd1);
        chk("wrap_count", 64'(cnt_w), 64'd3);
        chk("sat_ready", {62'd0, pr_s, pr_w}, 64'd3);

        push(40'h02FFFFFFFE, 16'd5, 1'b0);
        send(32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 1'b0);
        send(32'd0, 1'b0);
        send(32'd1, 1'b1);
        chk("sat_hold_out", 64'(out_s), 64'h1FFFFFFFF);
        chk("sat_hold_count", 64'(cnt_s), 64'd5);
        chk("wrap_hold_out", 64'(out_w), 64'h0FFFFFFFE);
        idle(2);

        // Backpressure: result held for 5 cycles, then same-cycle drain and reload.
        acc_ready = 1'b0;
        push(40'd30, 16'd2, 1'b0);
        send(32'd10, 1'b0);
        send(32'd20, 1'b1);
        prod_in    = 32'd40;
        prod_last  = 1'b1;
        prod_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_prod_ready", 64'(prod_ready), 64'd0);
            chk("bp_hold", {acc_valid, acc_out, acc_count}, {7'd0, 1'b1, 40'd30, 16'd2});
        end
        @(posedge clk);
        #1;
        push(40'd40, 16'd1, 1'b0);
        acc_ready = 1'b1;
        @(posedge clk);
        #1;
        prod_valid = 1'b0;
        prod_last  = 1'b0;
        chk("bp_reload", {acc_valid, acc_out}, {23'd0, 1'b1, 40'd40});
        idle(2);

        // Reset mid-vector discards the partial sum.
        send(32'd10, 1'b0);
        send(32'd20, 1'b0);
        rst = 1'b1;
        idle(1);
        chk("midrst_outputs", {acc_out, acc_count, acc_ovf, acc_valid}, 64'd0);
        chk("midrst_ready", 64'(prod_ready), 64'd0);
        rst = 1'b0;
        idle(1);
        chk("midrst_after", {acc_out, acc_count, acc_ovf, acc_valid}, 64'd0);
        push(40'd3, 16'd1, 1'b0);
        send(32'd3, 1'b1);
        idle(2);

        // Bubbles inside a vector.
        push(40'd7, 16'd3, 1'b0);
        send(32'd1, 1'b0);
        idle(4);
        send(32'd2, 1'b0);
        idle(1);
        send(32'd4, 1'b1);
        idle(4);

        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
Name: mac_accumulator

Overview:
- Downstream stage of the 16x16 unsigned multiplier in each processing element.
- Consumes the stream of 2*WIDTH-bit unsigned products and sums them into a wide accumulator, one dot product at a time.
- Delivers each finished dot product through a one-entry output buffer with a valid/ready handshake, so accumulation of the next vector overlaps the drain of the previous one.

Parameters:
- WIDTH, 16: multiplier operand width; product input is 2*WIDTH bits.
- ACC_WIDTH, 40: accumulator and result width; must be >= 2*WIDTH.
- SATURATE, 1: 1 = clamp at 2^ACC_WIDTH-1 on overflow; 0 = wrap modulo 2^ACC_WIDTH.

Ports:
- clk, input, 1: single clock, rising edge.
- rst, input, 1: synchronous active-high reset.
- prod_in, input, 2*WIDTH: unsigned product from the multiplier.
- prod_valid, input, 1: prod_in holds a valid term.
- prod_last, input, 1: qualifies prod_in as the final term of the current dot product.
- prod_ready, output, 1: block can accept a term this cycle.
- acc_out, output, ACC_WIDTH: completed dot-product sum.
- acc_ovf, output, 1: overflow occurred during this result's accumulation (sticky per vector).
- acc_count, output, 16: number of terms in this result, saturating at 65535.
- acc_valid, output, 1: acc_out, acc_ovf and acc_count are valid.
- acc_ready, input, 1: downstream accepts the result.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: acc_out=0, acc_ovf=0, acc_count=0, acc_valid=0. Internal running sum, running count, running ovf and the first flag are all cleared, with first=1.
- Reset mid-vector discards the partial sum and any pending result. No output is produced for the discarded work.
- prod_ready = !acc_valid || acc_ready. It is combinational, is independent of prod_valid, and is forced to 0 while rst=1.
- A term is accepted when prod_valid && prod_ready.
- Arithmetic on an accepted term:
  - prod_in is zero-extended to ACC_WIDTH+1 bits. base = first ? 0 : sum. s = base + prod_in.
  - Overflow when s[ACC_WIDTH]=1. The result is 2^ACC_WIDTH-1 if SATURATE=1, otherwise s[ACC_WIDTH-1:0].
  - Once saturated, the sum stays at max for the rest of the vector.
  - Count: cnt_next = first ? 1 : min(cnt+1, 65535).
  - Ovf: ovf_next = (first ? 0 : ovf) | overflow_this_term.
- Accepted term with prod_last=0: sum, cnt and ovf are updated, and first is cleared.
- Accepted term with prod_last=1:
  - The output register loads sum_next, cnt_next and ovf_next, and acc_valid=1 the next cycle.
  - The running state returns to first=1. Latency from last-term acceptance to acc_valid is exactly 1 cycle.
- Single-term vector (prod_last on a term with first=1): result equals prod_in, with count 1 and ovf 0.
- Output handshake: when acc_valid && acc_ready and no new last term is accepted in the same cycle, acc_valid goes to 0 next cycle. Output values may hold.
- Simultaneous events: output handshake in the same cycle as a last-term accept loads the new result and keeps acc_valid=1. Back-to-back results sustain one per cycle.
- Stall: while acc_valid=1 && acc_ready=0, prod_ready=0 and all internal state holds. Output values are stable while acc_valid=1 and unacknowledged.
- prod_valid=0 cycles (bubbles) inside a vector do not disturb the sum.
- Throughput is 1 term per cycle while downstream is ready.
- FSM is implicit and has two running states: FIRST (first=1) and ACCUM (first=0). The transition to ACCUM happens on a non-last accept. The transition to FIRST happens on a last accept or on reset.

Test Plan:
- Basic dot product: rst, then terms 100, 200, 300 (last on 300), acc_ready=1 -> acc_valid exactly 1 cycle after the last accept, acc_out=600, acc_count=3, acc_ovf=0, acc_valid low the following cycle.
- Single term and back-to-back: last-flagged term 0xFFFFFFFF, then immediately 5 then 7 (last) -> first result 0xFFFFFFFF with count 1, second result 12 with count 2, no gap beyond bubbles. The first result must not be added to the second.
- Saturation: ACC_WIDTH=33, SATURATE=1, terms 0xFFFFFFFF x3 (last on 3rd) -> acc_out=0x1FFFFFFFF, acc_ovf=1, count=3. With SATURATE=0 -> acc_out=0x0FFFFFFFD, acc_ovf=1.
- Backpressure: result pending with acc_ready=0 for 5 cycles while prod_valid=1 -> prod_ready=0, output stable for all 5 cycles. Raise acc_ready together with a pending last term -> same-cycle handshake and reload, acc_valid stays 1 with the new sum.
- Reset mid-vector: terms 10, 20, assert rst 1 cycle, then 3 (last) -> acc_out=3, count=1. No result ever emitted for 10 and 20. All outputs 0 during and immediately after reset.
- Bubbles: terms 1, idle x4, 2, idle, 4 (last) -> acc_out=7, count=3.
